// File: rtl/motor_pwm_pkg.sv
// motor_pwm_pkg: channel state encoding and switch-level to duty-fraction decode
package motor_pwm_pkg;
    typedef enum logic [2:0] {STOP, FWD, REV, DRAIN, DEAD} state_t;
    localparam int K_L0 = 4;
    localparam int K_L1 = 3;
    localparam int K_L2 = 2;
    localparam int K_L3 = 1;
    function automatic int level_k(input logic [3:0] nib);
        return nib[0] ? K_L0 : nib[1] ? K_L1 : nib[2] ? K_L2 : nib[3] ? K_L3 : 0;
    endfunction
endpackage

// File: rtl/motor_pwm_chan.sv
// motor_pwm_chan: one H-bridge channel -- switch decode, direction FSM, duty ramp, PWM compare
module motor_pwm_chan
    import motor_pwm_pkg::*;
#(
    parameter int PERIOD    = 100,
    parameter int RAMP_STEP = 25,
    parameter int DEADTIME  = 2,
    parameter int CW        = $clog2(PERIOD),
    parameter int DW        = $clog2(PERIOD + 1)
) (
    input  logic          w5,
    input  logic          rst_n,
    input  logic          wrap,
    input  logic [CW-1:0] cnt,
    input  logic [7:0]    sw,
    output logic          pwm_en,
    output logic          in1,
    output logic          in2,
    output logic          busy,
    output logic          conflict
);
    localparam int TW = DEADTIME > 1 ? $clog2(DEADTIME) : 1;
    state_t        state_q, state_d;
    logic [DW-1:0] duty_q, duty_d, target;
    logic [TW-1:0] dead_q, dead_d;
    logic          dir_q, dir_d, req_fwd, req_rev, req_opp, draining;
    function automatic logic [DW-1:0] ramp(input logic [DW-1:0] d, input logic [DW-1:0] t);
        int di, ti;
        di = int'(d);
        ti = int'(t);
        return DW'(di < ti ? (di + RAMP_STEP > ti ? ti : di + RAMP_STEP)
                           : (di - RAMP_STEP < ti ? ti : di - RAMP_STEP));
    endfunction
    always_comb begin
        req_fwd  = |sw[3:0] && !(|sw[7:4]);
        req_rev  = |sw[7:4] && !(|sw[3:0]);
        req_opp  = dir_q ? req_fwd : req_rev;
        target   = DW'(PERIOD * (req_fwd ? level_k(sw[3:0]) : req_rev ? level_k(sw[7:4]) : 0) / 4);
        draining = state_q == DRAIN || req_opp;
        state_d  = state_q;
        duty_d   = duty_q;
        dir_d    = dir_q;
        dead_d   = dead_q;
        if (wrap) begin
            if (state_q == STOP || state_q == DEAD) begin
                if (state_q == STOP || int'(dead_q) + 1 >= DEADTIME) begin
                    duty_d  = ramp(duty_q, target);
                    state_d = req_fwd ? FWD : req_rev ? REV : STOP;
                    dir_d   = req_rev || (dir_q && !req_fwd);
                    dead_d  = '0;
                end else begin
                    dead_d = dead_q + 1'b1;
                end
            end else begin
                // a reversal first drains to zero under the old direction, then enters dead time
                duty_d  = ramp(duty_q, draining ? '0 : target);
                state_d = duty_d != '0 ? (draining ? DRAIN : state_q) : (draining ? DEAD : STOP);
            end
        end
        pwm_en   = DW'(cnt) < duty_q;
        in1      = state_q == FWD || (state_q == DRAIN && !dir_q);
        in2      = state_q == REV || (state_q == DRAIN && dir_q);
        busy     = rst_n && (state_q == DRAIN || state_q == DEAD || duty_q != target
                             || (state_q != STOP && req_opp));
        conflict = rst_n && |sw[3:0] && |sw[7:4];
    end
    always_ff @(posedge w5 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= STOP;
            duty_q  <= '0;
            dir_q   <= 1'b0;
            dead_q  <= '0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            dir_q   <= dir_d;
            dead_q  <= dead_d;
        end
    end
endmodule

// File: rtl/motor_pwm_ctrl.sv
// motor_pwm_ctrl: N_CH L298 motor channels sharing one PWM counter.
// Define MOTOR_SW_SYNC_EN to pass sw through 2-flop synchronisers before decode.
module motor_pwm_ctrl #(
    parameter int N_CH      = 2,
    parameter int PERIOD    = 100,
    parameter int RAMP_STEP = 25,
    parameter int DEADTIME  = 2
) (
    input  logic              w5,
    input  logic              rst_n,
    input  logic [8*N_CH-1:0] sw,
    output logic [N_CH-1:0]   pwm_en,
    output logic [N_CH-1:0]   in1,
    output logic [N_CH-1:0]   in2,
    output logic [N_CH-1:0]   busy,
    output logic [N_CH-1:0]   conflict
);
    localparam int CW = $clog2(PERIOD);
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              wrap;
    logic [8*N_CH-1:0] sw_s;
    always_comb begin
        wrap  = cnt_q == CW'(PERIOD - 1);
        cnt_d = wrap ? '0 : cnt_q + 1'b1;
    end
    always_ff @(posedge w5 or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`ifdef MOTOR_SW_SYNC_EN
    logic [8*N_CH-1:0] meta_q, sync_q;
    always_ff @(posedge w5 or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= sw;
            sync_q <= meta_q;
        end
    end
    assign sw_s = sync_q;
`else
    assign sw_s = sw;
`endif
    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        motor_pwm_chan #(.PERIOD(PERIOD), .RAMP_STEP(RAMP_STEP), .DEADTIME(DEADTIME)) u_chan (
            .w5       (w5),
            .rst_n    (rst_n),
            .wrap     (wrap),
            .cnt      (cnt_q),
            .sw       (sw_s[8*i +: 8]),
            .pwm_en   (pwm_en[i]),
            .in1      (in1[i]),
            .in2      (in2[i]),
            .busy     (busy[i]),
            .conflict (conflict[i])
        );
    end
endmodule

// File: tb/tb_motor_pwm_ctrl.sv
// tb_motor_pwm_ctrl: period-by-period directed vectors for motor_pwm_ctrl (PERIOD=100, RAMP_STEP=25, DEADTIME=2)
module tb_motor_pwm_ctrl;
    logic        w5 = 1'b0;
    logic        rst_n;
    logic [15:0] sw;
    logic [1:0]  pwm_en, in1, in2, busy, conflict;
    int          total = 0;
    int          bad = 0;

    typedef struct {
        logic [15:0] sw;
        int          hi0;
        logic        i1_0, i2_0, b0;
        int          hi1;
        logic        i1_1, i2_1, c1;
    } vec_t;
    vec_t tbl[21];

    motor_pwm_ctrl dut (
        .w5(w5), .rst_n(rst_n), .sw(sw), .pwm_en(pwm_en),
        .in1(in1), .in2(in2), .busy(busy), .conflict(conflict)
    );

    always #5 w5 = ~w5;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // applies a row's switches at cnt=0 and observes one full PWM period
    task automatic run_row(input int i);
        int   hi0, hi1;
        logic s_i1_0, s_i2_0, s_b0, s_i1_1, s_i2_1, s_c1;
        sw  = tbl[i].sw;
        hi0 = 0;
        hi1 = 0;
        for (int c = 0; c < 100; c++) begin
            hi0 += int'(pwm_en[0]);
            hi1 += int'(pwm_en[1]);
            if (c == 99) begin
                s_i1_0 = in1[0]; s_i2_0 = in2[0]; s_b0 = busy[0];
                s_i1_1 = in1[1]; s_i2_1 = in2[1]; s_c1 = conflict[1];
            end
            @(negedge w5);
        end
        chk($sformatf("r%0d_hi0", i), hi0, tbl[i].hi0);
        chk($sformatf("r%0d_in1_0", i), int'(s_i1_0), int'(tbl[i].i1_0));
        chk($sformatf("r%0d_in2_0", i), int'(s_i2_0), int'(tbl[i].i2_0));
        chk($sformatf("r%0d_busy0", i), int'(s_b0), int'(tbl[i].b0));
        chk($sformatf("r%0d_hi1", i), hi1, tbl[i].hi1);
        chk($sformatf("r%0d_in1_1", i), int'(s_i1_1), int'(tbl[i].i1_1));
        chk($sformatf("r%0d_in2_1", i), int'(s_i2_1), int'(tbl[i].i2_1));
        chk($sformatf("r%0d_conf1", i), int'(s_c1), int'(tbl[i].c1));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pwm_en"}, int'(pwm_en), 0);
        chk({tag, "_in1"}, int'(in1), 0);
        chk({tag, "_in2"}, int'(in2), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_conflict"}, int'(conflict), 0);
    endtask

    initial begin
        // ch0: fwd ramp to 100, reverse with drain and dead time, then rev 75; ch1: fwd 50 then conflict
        tbl[0]  = '{16'h0401,   0, 1'b0, 1'b0, 1'b1,  0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{16'h0401,  25, 1'b1, 1'b0, 1'b1, 25, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{16'h0401,  50, 1'b1, 1'b0, 1'b1, 50, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{16'h0401,  75, 1'b1, 1'b0, 1'b1, 50, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{16'h0401, 100, 1'b1, 1'b0, 1'b0, 50, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{16'h1110, 100, 1'b1, 1'b0, 1'b1, 50, 1'b1, 1'b0, 1'b1};
        tbl[6]  = '{16'h1110,  75, 1'b1, 1'b0, 1'b1, 25, 1'b1, 1'b0, 1'b1};
        tbl[7]  = '{16'h1110,  50, 1'b1, 1'b0, 1'b1,  0, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{16'h1110,  25, 1'b1, 1'b0, 1'b1,  0, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{16'h1110,   0, 1'b0, 1'b0, 1'b1,  0, 1'b0, 1'b0, 1'b1};
        tbl[10] = '{16'h1110,   0, 1'b0, 1'b0, 1'b1,  0, 1'b0, 1'b0, 1'b1};
        tbl[11] = '{16'h1110,  25, 1'b0, 1'b1, 1'b1,  0, 1'b0, 1'b0, 1'b1};
        tbl[12] = '{16'h1110,  50, 1'b0, 1'b1, 1'b1,  0, 1'b0, 1'b0, 1'b1};
        tbl[13] = '{16'h1110,  75, 1'b0, 1'b1, 1'b1,  0, 1'b0, 1'b0, 1'b1};
        tbl[14] = '{16'h1110, 100, 1'b0, 1'b1, 1'b0,  0, 1'b0, 1'b0, 1'b1};
        tbl[15] = '{16'h1120, 100, 1'b0, 1'b1, 1'b1,  0, 1'b0, 1'b0, 1'b1};
        tbl[16] = '{16'h1120,  75, 1'b0, 1'b1, 1'b0,  0, 1'b0, 1'b0, 1'b1};
        // after mid-run reset: ch0 0x0E (bit1 wins -> 75 %), ch1 0xC0 (bit6 wins -> rev 50 %)
        tbl[17] = '{16'hC00E,   0, 1'b0, 1'b0, 1'b1,  0, 1'b0, 1'b0, 1'b0};
        tbl[18] = '{16'hC00E,  25, 1'b1, 1'b0, 1'b1, 25, 1'b0, 1'b1, 1'b0};
        tbl[19] = '{16'hC00E,  50, 1'b1, 1'b0, 1'b1, 50, 1'b0, 1'b1, 1'b0};
        tbl[20] = '{16'hC00E,  75, 1'b1, 1'b0, 1'b0, 50, 1'b0, 1'b1, 1'b0};

        rst_n = 1'b0;
        sw    = 16'h0000;
        #1;
        chk_all_zero("reset");
        repeat (3) @(negedge w5);
        rst_n = 1'b1;
        for (int i = 0; i <= 16; i++) run_row(i);

        // reset asserted mid-period while ch0 is at 75 % REV and pwm_en is high
        repeat (10) @(negedge w5);
        chk("pre_rst_pwm0", int'(pwm_en[0]), 1);
        chk("pre_rst_in2_0", int'(in2[0]), 1);
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        @(negedge w5);
        chk_all_zero("midrst_hold");
        rst_n = 1'b1;
        for (int i = 17; i <= 20; i++) run_row(i);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/motor_pwm_ctrl.md
MOTOR_PWM_CTRL -- requirements
Module: motor_pwm_ctrl

Interface
REQ-001 The block SHALL have parameter N_CH, default 2, number of independent motor channels.
REQ-002 The block SHALL have parameter PERIOD, default 100, PWM period in clocks; it must be a multiple of 4 and at least 8.
REQ-003 The block SHALL have parameter RAMP_STEP, default 25, duty change per PWM period.
REQ-004 The block SHALL have parameter DEADTIME, default 2, count of whole PWM periods with both bridge inputs low before a reversal.
REQ-005 Port list SHALL be:
- w5  in  1  system clock, 100 MHz.
- rst_n  in  1  reset; asynchronous assert, active-low.
- sw  in  8*N_CH  switches; per channel bits 0-3 select forward 100/75/50/25 %, bits 4-7 select reverse 100/75/50/25 %.
- pwm_en  out  N_CH  L298 enable (PWM) per channel.
- in1  out  N_CH  L298 IN1 per channel.
- in2  out  N_CH  L298 IN2 per channel.
- busy  out  N_CH  high while a channel is ramping, draining or in dead time.
- conflict  out  N_CH  high while forward and reverse switches are both set.
REQ-006 The block SHALL use one clock (w5); all flops SHALL reset asynchronously on rst_n low.

Function
REQ-007 Decode priority SHALL be lowest bit wins within a direction: bit0 > bit1 > bit2 > bit3, and bit4 > bit5 > bit6 > bit7.
REQ-008 Target duty SHALL be PERIOD*k/4, with k=4,3,2,1 for the selected level and k=0 when no switch is set.
REQ-009 Any forward bit together with any reverse bit SHALL give target 0 and assert conflict; direction is unchanged.
REQ-010 One shared counter SHALL run 0..PERIOD-1, then wrap to 0.
REQ-011 Each channel SHALL set pwm_en = (cnt < duty), combinational from registered cnt and duty.
REQ-012 Duty, state and direction SHALL update only in the cycle where cnt = PERIOD-1, so PWM is glitch-free.
REQ-013 Ramp SHALL move duty toward target by RAMP_STEP each period, saturating at target, never below 0 or above PERIOD.
REQ-014 Each channel SHALL have states STOP, FWD, REV, DRAIN, DEAD.
REQ-015 STOP SHALL mean duty 0 and in1 = in2 = 0; a nonzero target moves to FWD or REV.
REQ-016 FWD SHALL drive in1=1, in2=0; REV SHALL drive in1=0, in2=1.
REQ-017 From FWD or REV:
- target 0 ramps duty down, then returns to STOP when duty reaches 0.
- an opposite-direction request moves to DRAIN.
REQ-018 DRAIN SHALL ramp duty to 0 while holding the old direction, then enter DEAD.
REQ-019 DEAD SHALL hold in1 = in2 = 0 and duty 0 for DEADTIME periods, then go to the currently requested direction, or STOP if none.
REQ-020 The request SHALL be re-sampled at every period boundary; a request cancelled in DRAIN still completes DRAIN, DEAD and then STOP.
REQ-021 A 100 % duty SHALL give pwm_en constantly high; 0 % SHALL give it constantly low.

Reset
REQ-022 On rst_n low, all outputs SHALL be 0, cnt = 0, all duty = 0, all states = STOP.
REQ-023 Reset mid-operation SHALL take effect immediately, with no ramp-down and no dead time.
REQ-024 After rst_n rises, the first possible duty change SHALL be at the first wrap.

Configuration
REQ-025 With MOTOR_SW_SYNC_EN defined, each sw bit SHALL pass through a 2-flop synchroniser (reset to 0) before decode, adding 2 cycles of latency.
REQ-026 Without MOTOR_SW_SYNC_EN, sw SHALL be decoded directly and must be synchronous to w5.

Structure
REQ-027 A shared package SHALL hold the state enum (STOP, FWD, REV, DRAIN, DEAD) and the level-to-k decode constants.
REQ-028 Per-channel logic (decode, FSM, ramp, compare) SHALL be sub-module motor_pwm_chan, instantiated N_CH times; counter and optional synchroniser SHALL live in the top.

Verification (PERIOD=100, RAMP_STEP=25, DEADTIME=2)
REQ-029 Ch0 sw=0x01 from STOP -> duty 25, 50, 75, 100 at successive wraps; in1=1, in2=0; busy clears at 100.
REQ-030 Ch0 sw=0x04 steady -> pwm_en high exactly 50 of every 100 cycles.
REQ-031 Ch0 at 100 % FWD, sw changed to 0x10 -> duty falls 75..0 with in1 held 1, then 2 periods with in1=in2=0, then in2=1 and duty rises to 100.
REQ-032 Ch1 sw=0x11 -> conflict=1, duty ramps to 0, state STOP; ch0 unaffected.
REQ-033 rst_n pulsed low at 75 % REV -> all outputs 0 in the same cycle; restart from STOP.
REQ-034 With MOTOR_SW_SYNC_EN, a sw change 2 cycles before a wrap -> first duty change one period later than without the macro.
